// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end: the keypad scanner FSM
// state type, the command code width, the {row,col} -> command map, and small
// helpers for decoding the active-low row bus.
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } scan_state_e;

    // Indexed by {row, col}; identity map so code = row*4 + col.
    localparam logic [CMD_W-1:0] KEY_MAP [16] = '{
        4'h0, 4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB,
        4'hC, 4'hD, 4'hE, 4'hF
    };

    // True when exactly one row is pulled low.
    function automatic logic one_row_low(input logic [3:0] rows);
        logic [3:0] v;
        v = ~rows;
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Index of the lowest-numbered low row (only meaningful when one is low).
    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a bus of independent asynchronous bits.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous reset, active-low (flops load RST_VAL)
//   d_i     - asynchronous input bus
//   q_o     - synchronised output bus (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces press and release, and
// issues one command code per accepted press.
// Ports:
//   clock     - system clock
//   reset     - asynchronous reset, active-low
//   row_n     - keypad rows, active-low, asynchronous (pulled up externally)
//   col_n     - column drive, active-low one-hot
//   cmd       - command code, NOP_CMD except on an issue cycle
//   cmd_valid - one-cycle pulse aligned with an issued cmd
//   key_down  - high from issue until the release has been debounced
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat while a key is
// held (parameters REPEAT_DELAY and REPEAT_RATE).
// -----------------------------------------------------------------------------
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int               SCAN_DIV     = 1000,
    parameter int               DEBOUNCE_CYC = 20000,
    parameter logic [CMD_W-1:0] NOP_CMD      = 4'hF
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int               REPEAT_DELAY = 500000,
    parameter int               REPEAT_RATE  = 100000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYC - 1);

    logic [3:0]       rs;
    scan_state_e      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             vld_q, vld_d;
    logic             kd_q, kd_d;
    logic [3:0]       row_pat;
    logic [CMD_W-1:0] key_code;

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (row_n),
        .q_o    (rs)
    );

    // Row pattern expected while the latched key is the only one held.
    assign row_pat  = ~(4'b0001 << row_q);
    assign key_code = KEY_MAP[{row_q, col_q}];

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rep_q, rep_d;   // set once the first repeat has fired

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
            rep_q <= rep_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        cmd_d   = NOP_CMD;
        vld_d   = 1'b0;
        kd_d    = kd_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_d   = rpt_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    // Ghosting / multi-key presses are skipped like an idle column.
                    if (one_row_low(rs)) begin
                        row_d   = low_row_idx(rs);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs != row_pat) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Outputs are registered, so they are set up on the way in.
                    state_d = EMIT;
                    cmd_d   = key_code;
                    vld_d   = 1'b1;
                    kd_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                // Counts cycles since the issue cycle; EMIT itself is cycle 0.
                rpt_d   = RW'(1);
                rep_d   = 1'b0;
`endif
            end
            WAIT_RELEASE: begin
                if (rs == 4'b1111) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                        dwell_d = '0;
                        kd_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                if (rs[row_q]) begin
                    rpt_d = '0;
                    rep_d = 1'b0;
                end else if (rpt_q == (rep_q ? RATE_LAST : DELAY_LAST)) begin
                    cmd_d = key_code;
                    vld_d = 1'b1;
                    rpt_d = '0;
                    rep_d = 1'b1;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
`else
                // Without auto-repeat a held key never re-issues.
`endif
            end
            default: begin
                state_d = SCAN;
            end
        endcase
        col_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            col_n_q <= 4'b1110;
            cmd_q   <= NOP_CMD;
            vld_q   <= 1'b0;
            kd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            col_n_q <= col_n_d;
            cmd_q   <= cmd_d;
            vld_q   <= vld_d;
            kd_q    <= kd_d;
        end
    end

    assign col_n     = col_n_q;
    assign cmd       = cmd_q;
    assign cmd_valid = vld_q;
    assign key_down  = kd_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYC=8.
// A keypad model turns the pressed-key matrix and the column drive into rows.
// Each run starts from reset so the scan phase is known; cycle N is the cycle
// after the Nth rising edge following reset release.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam logic [3:0] NOP = 4'hF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       key_down;

    logic [3:0] keys [4];   // keys[row][col] = 1 when pressed
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t sb[$];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8),
        .NOP_CMD      (NOP)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY (40),
        .REPEAT_RATE  (10)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .key_down  (key_down)
    );

    always #5 clock = ~clock;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r] & ~col_n);
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] col_pat(input int k);
        return ~(4'b0001 << k);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic push(input logic [3:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    endtask

    // Monitor: every issued command must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (cmd_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: cmd=%0h at cycle %0d, none expected", cmd, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("pulse_cmd", 32'(cmd), 32'(e.code));
                        check("pulse_cycle", cyc, e.at);
                    end
                end else begin
                    check("idle_cmd", 32'(cmd), 32'(NOP));
                end
            end
        end
    end

    initial begin
        clear_keys();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_col_n", 32'(col_n), 32'h0000_000E);
        check("rst_cmd", 32'(cmd), 32'(NOP));
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_key_down", 32'(key_down), 0);

        // Idle: columns rotate every 4 cycles, nothing issued.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wait_cyc(i);
            check("idle_col_n", 32'(col_n), 32'(col_pat((i / 4) % 4)));
        end
        #1 check("idle_pending", sb.size(), 0);

        // Clean press (1,2): detected at sample cycle 11, issued at cycle 20.
        clear_keys();
        keys[1][2] = 1'b1;
        do_reset();
        push(4'h6, 20);
        wait_cyc(19);
        check("press_kd_before", 32'(key_down), 0);
        wait_cyc(20);
        check("press_kd_issue", 32'(key_down), 1);
        wait_cyc(30);
        keys[3][2] = 1'b1;          // second key while holding: ignored
        wait_cyc(40);
        check("press_kd_held", 32'(key_down), 1);
        check("press_col_held", 32'(col_n), 32'h0000_000B);
        clear_keys();               // release seen on rs at 42, debounced by 49
        wait_cyc(49);
        check("release_kd_49", 32'(key_down), 1);
        wait_cyc(50);
        check("release_kd_50", 32'(key_down), 0);
        check("release_col_next", 32'(col_n), 32'h0000_0007);
        wait_cyc(80);
        #1 check("press_pending", sb.size(), 0);

        // Bouncing (0,0): low 3 / high 1 until cycle 40, then stable.
        // Col 0 is next sampled at cycle 53 (stable) -> issue at 62.
        clear_keys();
        keys[0][0] = 1'b1;
        do_reset();
        push(4'h0, 62);
        while (cyc < 40) begin
            keys[0][0] = (cyc % 4 != 3);
            @(negedge clock);
        end
        keys[0][0] = 1'b1;
        wait_cyc(70);
        clear_keys();
        wait_cyc(100);
        #1 check("bounce_pending", sb.size(), 0);

        // Ghost: rows 1 and 3 on col 1 -> never accepted, scan keeps rotating.
        clear_keys();
        keys[1][1] = 1'b1;
        keys[3][1] = 1'b1;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wait_cyc(i);
            check("ghost_col_n", 32'(col_n), 32'(col_pat((i / 4) % 4)));
        end
        check("ghost_kd", 32'(key_down), 0);
        clear_keys();

        // Reset during WAIT_RELEASE, key still held -> issued once more.
        keys[1][2] = 1'b1;
        do_reset();
        push(4'h6, 20);
        wait_cyc(30);
        check("mid_kd_before", 32'(key_down), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_col_n", 32'(col_n), 32'h0000_000E);
        check("mid_rst_kd", 32'(key_down), 0);
        check("mid_rst_valid", 32'(cmd_valid), 0);
        push(4'h6, 20);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_cyc(40);
        clear_keys();
        wait_cyc(60);
        #1 check("mid_pending", sb.size(), 0);

        // Key (3,3): issued at 24 (code F equals NOP, valid still pulses).
        keys[3][3] = 1'b1;
        do_reset();
        push(4'hF, 24);
`ifdef KEYPAD_REPEAT_EN
        push(4'hF, 64);
        push(4'hF, 74);
        push(4'hF, 84);
        push(4'hF, 94);
`endif
        wait_cyc(100);
        clear_keys();
        wait_cyc(130);
        check("k33_kd_released", 32'(key_down), 0);
        #1 check("k33_pending", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage of the calculator. Scans a 4x4 active-low matrix keypad and debounces the contacts.
- Each accepted key press is converted to a 4-bit command code, which drives the calculator's cmd input.
- Emits exactly one command per physical press; between presses cmd idles at a no-op code.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (legal range >= 4).
- DEBOUNCE_CYC, 20000, consecutive stable cycles required to accept a press or a release (legal range >= 2).
- NOP_CMD, 4'hF, value driven on cmd when no command is being issued.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- row_n  in  4  keypad rows, active-low, externally pulled up, asynchronous to clock.
- col_n  out  4  keypad column drive, active-low one-hot.
- cmd  out  4  command code; holds NOP_CMD except during the single issue cycle.
- cmd_valid  out  1  one-cycle pulse, aligned with the issued cmd.
- key_down  out  1  high while an accepted key is held, until its release is debounced.

Behaviour:
- Reset (reset=0, asynchronous): col_n=4'b1110, cmd=NOP_CMD, cmd_valid=0, key_down=0, FSM=SCAN, column index=0, counters=0, row synchroniser=4'b1111.
- row_n passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- SCAN:
  - Drive column k. Dwell counter runs 0..SCAN_DIV-1.
  - On the last dwell cycle, sample rs.
  - Exactly one row r low: latch (r,k), clear the debounce counter, go to DEBOUNCE. Column k stays driven.
  - Zero rows low, or two or more rows low (ghost/multi-key): k=k+1 mod 4 (3 wraps to 0), dwell restarts.
- DEBOUNCE:
  - Each cycle, compare rs with the latched one-hot pattern.
  - Mismatch: return to SCAN at column k+1.
  - Counter reaches DEBOUNCE_CYC-1 with every cycle matching: go to EMIT.
- EMIT (1 cycle): cmd=KEY_MAP[{r,k}], cmd_valid=1, key_down goes 1. Next state is WAIT_RELEASE.
- WAIT_RELEASE:
  - Column k stays driven; cmd=NOP_CMD, cmd_valid=0.
  - Release counter increments while rs==4'b1111 and clears on any low row.
  - Counter reaches DEBOUNCE_CYC-1: key_down=0, go to SCAN at column k+1.
  - Other keys pressed while holding are ignored: no second command until release.
- Latency: cmd_valid rises exactly DEBOUNCE_CYC+1 cycles after the SCAN sample cycle that detected the key.
- All outputs are registered.
- Reset mid-press: outputs return to reset values immediately. A key still held after reset is rescanned and issued once more.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 500000) and REPEAT_RATE (default 100000).
  - In WAIT_RELEASE, with the key continuously held, re-issue the same cmd with a one-cycle cmd_valid REPEAT_DELAY cycles after EMIT, then every REPEAT_RATE cycles.
  - Any release glitch resets the repeat timer.
- Undefined: strictly one command per press. The REPEAT parameters and timer are absent.

Decomposition:
- Package calc_pkg:
  - typedef for the scanner FSM state enum (SCAN, DEBOUNCE, EMIT, WAIT_RELEASE).
  - localparam KEY_MAP, a 16-entry array of 4-bit codes indexed by {row,col}. Default is identity: code = row*4+col.
  - CMD width constant, 4.
- One sub-module: sync_2ff (4-bit, reset value 1s), the reusable 2-flop synchroniser.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, NOP_CMD=4'hF):
- No keys pressed for 64 cycles -> col_n rotates 1110,1101,1011,0111 every 4 cycles; cmd_valid never asserted; cmd=4'hF.
- Key (row1,col2) held clean -> exactly one cmd_valid pulse with cmd=4'h6, DEBOUNCE_CYC+1 cycles after detection; key_down=1 until release plus 8 cycles; no further pulses.
- Key (row0,col0) bouncing, low 3 cycles / high 1 cycle repeatedly, then stable -> no pulse during bounce; one pulse, cmd=4'h0, after 8 stable cycles.
- Rows 1 and 3 both low on col1 -> no command ever; scan keeps rotating.
- Reset pulled low during WAIT_RELEASE -> col_n=1110, key_down=0, cmd_valid=0 in the same cycle; key still held after reset release -> one new pulse.
- KEYPAD_REPEAT_EN, REPEAT_DELAY=40, REPEAT_RATE=10, key (3,3) held 80 cycles after EMIT -> pulses at EMIT, +40, +50, +60, +70; cmd=4'hF equals NOP_CMD but cmd_valid still pulses.
